serial_alu_unit: RTL

Area-reduced 32-bit integer ALU that computes one 4-bit nibble per cycle over 8 cycles, propagating carry between nibbles. It serves the low-area core variant and long-latency ops that can tolerate multi-cycle execution. It is the sequential, carry-chained counterpart of the 8-slice parallel ALU array and uses the same `ALUControl` encoding. Operands enter, and results leave, through valid/ready handshakes.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_nibble_slice.sv | 41 ++++
 rtl/serial_alu_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: operation encoding and serial FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Ops that run through the adder as A + ~B + 1.
    function automatic logic uses_sub(input logic [3:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// One 4-bit ALU slice; the serial unit reuses it for every nibble.
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    input  logic       carry_in,
    output logic [3:0] result,
    output logic       carry_out
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    // Adder shared by arithmetic ops; B inverted for subtract-style ops.
    always_comb begin
        b_eff = uses_sub(op) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, carry_in};
    end

    // Select the nibble result; logic ops and unknown codes produce no carry.
    always_comb begin
        result    = 4'h0;
        carry_out = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: begin
                result    = sum[3:0];
                carry_out = sum[4];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: begin
                result    = 4'h0;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_unit.sv
// Nibble-serial ALU: one 4-bit slice per cycle, carry chained through a flop.
module serial_alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic [3:0]           ALUControl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] Result,
    output logic                 Zero,
    output logic                 busy
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [3:0]    op_q, op_d;
    // Partial result of the op in flight; kept apart so Result holds until the next DONE.
    logic [W-5:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;

    logic [3:0]    nib_res;
    logic          nib_cout;
    logic          slt_flag;
    logic [W-1:0]  final_res;

    alu_nibble_slice u_slice (
        .a         (a_q[3:0]),
        .b         (b_q[3:0]),
        .op        (op_q),
        .carry_in  (carry_q),
        .result    (nib_res),
        .carry_out (nib_cout)
    );

    // Last-nibble finalisation: compares reduce to a single flag bit.
    always_comb begin
        // On the last nibble a_q[3]/b_q[3] are the operand sign bits.
        slt_flag = nib_res[3] ^ ((a_q[3] != b_q[3]) && (nib_res[3] != a_q[3]));
        case (op_q)
            ALU_SLT:  final_res = {{(W - 1){1'b0}}, slt_flag};
            ALU_SLTU: final_res = {{(W - 1){1'b0}}, ~nib_cout};
            default:  final_res = {nib_res, acc_q};
        endcase
    end

    // FSM next state and datapath updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = ALUControl;
                    cnt_d   = '0;
                    carry_d = uses_sub(ALUControl);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {4'h0, a_q[W-1:4]};
                b_d     = {4'h0, b_q[W-1:4]};
                acc_d   = {nib_res, acc_q[W-5:4]};
                carry_d = nib_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = final_res;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        Result    = result_q;
        Zero      = (result_q == '0);
    end

endmodule
